// File: rtl/alu_issue_controller.sv
// ALU issue front end: decodes RV32I ALU instructions, queues them, and
// drives the ALU one operation at a time with an in-order stalling writeback.
//
// state | meaning
// IDLE  | nothing in flight; waiting for a queued instruction
// EXEC  | ALU enabled for one cycle with the issued operands
// HOLD  | result presented on writeback until the consumer takes it
module alu_issue_controller #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instValid,
    output logic             instReady,
    input  logic [31:0]      instWord,
    input  logic [31:0]      rs1Data,
    input  logic [31:0]      rs2Data,
    output logic [31:0]      aluOperandA,
    output logic [31:0]      aluOperandB,
    output logic [3:0]       aluOp,
    output logic             aluEnable,
    input  logic [31:0]      aluResult,
    input  logic             aluZero,
    output logic             wbValid,
    input  logic             wbReady,
    output logic [4:0]       wbRd,
    output logic [31:0]      wbData,
    output logic             wbZero,
    output logic             illegalInst,
    output logic [CNT_W-1:0] queueCount
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t state, next_state;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] shamt_b;
    logic        dec_legal;
    logic [3:0]  dec_op;
    logic [31:0] dec_b;
    logic        inst_unused;

    logic        accept;
    logic        push;
    logic        pop;
    logic        fifo_empty;

    logic [3:0]       op_mem [DEPTH];
    logic [31:0]      a_mem  [DEPTH];
    logic [31:0]      b_mem  [DEPTH];
    logic [4:0]       rd_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [4:0]       issue_rd;

    assign opcode      = instWord[6:0];
    assign funct3      = instWord[14:12];
    assign funct7      = instWord[31:25];
    assign imm_i       = {{20{instWord[31]}}, instWord[31:20]};
    assign shamt_b     = {27'b0, instWord[24:20]};
    // rs1 field is resolved upstream; rs1Data carries its value
    assign inst_unused = ^instWord[19:15];

    // Decode the offered instruction into ALU op, operand B and legality
    always_comb begin
        dec_legal = 1'b0;
        dec_op    = OP_ADD;
        dec_b     = rs2Data;
        if (opcode == 7'b0110011) begin
            case (funct3)
                3'b000: begin
                    if (funct7 == 7'h00) begin
                        dec_legal = 1'b1;
                        dec_op    = OP_ADD;
                    end else if (funct7 == 7'h20) begin
                        dec_legal = 1'b1;
                        dec_op    = OP_SUB;
                    end
                end
                3'b001: begin dec_legal = (funct7 == 7'h00); dec_op = OP_SLL;  end
                3'b010: begin dec_legal = (funct7 == 7'h00); dec_op = OP_SLT;  end
                3'b011: begin dec_legal = (funct7 == 7'h00); dec_op = OP_SLTU; end
                3'b100: begin dec_legal = (funct7 == 7'h00); dec_op = OP_XOR;  end
                3'b101: begin
                    if (funct7 == 7'h00) begin
                        dec_legal = 1'b1;
                        dec_op    = OP_SRL;
                    end else if (funct7 == 7'h20) begin
                        dec_legal = 1'b1;
                        dec_op    = OP_SRA;
                    end
                end
                3'b110: begin dec_legal = (funct7 == 7'h00); dec_op = OP_OR;   end
                3'b111: begin dec_legal = (funct7 == 7'h00); dec_op = OP_AND;  end
            endcase
        end else if (opcode == 7'b0010011) begin
            dec_b = imm_i;
            case (funct3)
                3'b000: begin dec_legal = 1'b1; dec_op = OP_ADD;  end
                3'b010: begin dec_legal = 1'b1; dec_op = OP_SLT;  end
                3'b011: begin dec_legal = 1'b1; dec_op = OP_SLTU; end
                3'b100: begin dec_legal = 1'b1; dec_op = OP_XOR;  end
                3'b110: begin dec_legal = 1'b1; dec_op = OP_OR;   end
                3'b111: begin dec_legal = 1'b1; dec_op = OP_AND;  end
                3'b001: begin
                    dec_b     = shamt_b;
                    dec_legal = (funct7 == 7'h00);
                    dec_op    = OP_SLL;
                end
                3'b101: begin
                    dec_b = shamt_b;
                    if (funct7 == 7'h00) begin
                        dec_legal = 1'b1;
                        dec_op    = OP_SRL;
                    end else if (funct7 == 7'h20) begin
                        dec_legal = 1'b1;
                        dec_op    = OP_SRA;
                    end
                end
            endcase
        end
    end

    assign instReady  = (queueCount < CNT_W'(DEPTH));
    assign fifo_empty = (queueCount == '0);
    assign accept     = instValid && instReady;
    assign push       = accept && dec_legal;

    // Queue storage; contents are don't-care until counted as valid
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr] <= dec_op;
            a_mem[wr_ptr]  <= rs1Data;
            b_mem[wr_ptr]  <= dec_b;
            rd_mem[wr_ptr] <= instWord[11:7];
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            queueCount <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            queueCount <= queueCount + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Illegal pulse follows the accepting edge only
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) illegalInst <= 1'b0;
        else        illegalInst <= accept && !dec_legal;
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // FSM next state and queue pop
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = EXEC;
                end
            end
            EXEC: next_state = HOLD;
            HOLD: begin
                if (wbReady) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        next_state = EXEC;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign aluEnable = (state == EXEC);
    assign wbValid   = (state == HOLD);

    // Issue registers hold the last popped entry so the ALU inputs stay put
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            aluOp       <= OP_ADD;
            aluOperandA <= '0;
            aluOperandB <= '0;
            issue_rd    <= '0;
        end else if (pop) begin
            aluOp       <= op_mem[rd_ptr];
            aluOperandA <= a_mem[rd_ptr];
            aluOperandB <= b_mem[rd_ptr];
            issue_rd    <= rd_mem[rd_ptr];
        end
    end

    // Writeback capture at the end of the single EXEC cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wbRd   <= '0;
            wbData <= '0;
            wbZero <= 1'b0;
        end else if (state == EXEC) begin
            wbRd   <= issue_rd;
            wbData <= aluResult;
            wbZero <= aluZero;
        end
    end

endmodule

// File: doc/alu_issue_controller.md
# alu_issue_controller

Issue-side front end for the ALU. Accepts RV32I register-register and register-immediate ALU instructions, with their source register values, through a valid/ready handshake. Decodes each into the ALU's 4-bit operation code and operands, and buffers them in a small FIFO. Drives the ALU one operation at a time and presents each result on a stalling writeback handshake, in program order.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `CNT_W`, $clog2(DEPTH)+1, width of `queueCount`.

- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `instValid`  in  1  instruction offered.
- `instReady`  out  1  controller can accept.
- `instWord`  in  32  RV32I instruction.
- `rs1Data`  in  32  value of rs1, qualified by `instValid`.
- `rs2Data`  in  32  value of rs2, qualified by `instValid`.
- `aluOperandA`  out  32  to ALU `operandA`.
- `aluOperandB`  out  32  to ALU `operandB`.
- `aluOp`  out  4  to ALU `op`.
- `aluEnable`  out  1  to ALU `enALU`.
- `aluResult`  in  32  from ALU `result`; combinational.
- `aluZero`  in  1  from ALU `flagZero`.
- `wbValid`  out  1  writeback data valid.
- `wbReady`  in  1  writeback consumer accepts.
- `wbRd`  out  5  destination register.
- `wbData`  out  32  result.
- `wbZero`  out  1  captured zero flag.
- `illegalInst`  out  1  one-cycle pulse: accepted instruction was not decodable.
- `queueCount`  out  CNT_W  FIFO occupancy.

## Operation

**ALU op codes**
- ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9.

**R-type decode** (opcode 0110011)
- funct3 000: ADD when funct7=0000000, SUB when funct7=0100000.
- funct3 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND; each requires funct7=0000000.
- funct3 101: SRL when funct7=0000000, SRA when funct7=0100000.
- operandA=rs1Data, operandB=rs2Data.

**I-type decode** (opcode 0010011)
- funct3 000 ADDI, 010 SLTI, 011 SLTIU, 100 XORI, 110 ORI, 111 ANDI.
  - operandB = sign-extended instWord[31:20].
  - SLTIU compares that sign-extended value unsigned.
- funct3 001 SLLI requires instWord[31:25]=0000000.
- funct3 101 SRLI when instWord[31:25]=0000000, SRAI when 0100000.
- For shifts, operandB = {27'b0, instWord[24:20]}.
- operandA=rs1Data.

**Illegal instructions**
- Any other opcode, funct7 or shift encoding is illegal.
- It is still accepted (handshake completes) but is not enqueued.
- `illegalInst` is high for the one cycle after the accepting edge.

**FIFO**
- Entry = {op, A, B, rd}.
- Push on `instValid && instReady && legal`.
- `instReady = (queueCount < DEPTH)`.
- Push and pop on the same edge leave the count unchanged. Pointers wrap modulo DEPTH.

**FSM**
- IDLE: if FIFO non-empty, pop head into issue registers → EXEC.
- EXEC (exactly one cycle): `aluEnable`=1.
  - On the exiting edge, capture `aluResult` into `wbData`, `aluZero` into `wbZero`, issue rd into `wbRd`.
  - Set `wbValid` → HOLD.
- HOLD: `wbValid`=1; `wbRd`, `wbData` and `wbZero` stable.
  - On `wbValid && wbReady`: if FIFO non-empty, pop → EXEC; else → IDLE with `wbValid`=0.
- Outside EXEC, `aluOperandA`, `aluOperandB` and `aluOp` hold the last issued values, with `aluEnable`=0.
- rd=0 executes normally; the consumer discards it.

## Timing
- **Reset values:** all outputs 0 except `instReady`=1. FSM in IDLE, FIFO empty.
- **Reset mid-operation:** the FIFO is flushed and the in-flight result is lost. `wbValid` drops asynchronously.
- **Latency:** accept at edge N into an empty, idle controller → `aluEnable` high during cycle N+1 → `wbValid` high from edge N+2.
- **Throughput:** one result per 2 cycles with `wbReady` tied high.
- `instReady` depends only on registered state; there is no combinational path from `wbReady`.
- **Full FIFO:** `instReady`=0, and `instValid` is ignored without loss.
- An offer with `instReady`=0 does not assert `illegalInst`.

## Test plan
- **ADD.** `instWord`=0x002081B3 (add x3,x1,x2), rs1=5, rs2=7 → `aluOp`=0, `aluEnable` high for exactly 1 cycle; 2 cycles after accept, `wbValid`=1, `wbRd`=3, `wbData`=12, `wbZero`=0.
- **SRAI.** 0x40435293 (srai x5,x6,4), rs1=0x80000000 → `aluOp`=9, `aluOperandB`=4, `wbData`=0xF8000000.
- **Sign extension and zero flag.** 0xFFF00093 (addi x1,x0,-1), rs1=0 → `wbData`=0xFFFFFFFF. Then 0x40108233 (sub x4,x1,x1), rs1=rs2=9 → `wbData`=0, `wbZero`=1.
- **Back-pressure.** DEPTH=4, `wbReady`=0, six back-to-back legal instructions → first reaches HOLD, `queueCount` reaches 4, `instReady`=0, sixth stalls. Release `wbReady` → all six results in order, each held until handshake.
- **Illegal.** 0x00002083 (load) → `illegalInst` pulses 1 cycle, `queueCount` unchanged, no `wbValid`, `instReady` stays 1.
- **Reset.** Reset asserted during HOLD with 3 queued → `wbValid`=0 and `queueCount`=0 immediately. After release, a new ADD completes normally.
